// File: rtl/instr_encoder.sv
// Assembly-to-machine-word encoder: validates operand windows, encodes into a
// 9-bit word and streams legal words to instruction memory at sequential addresses.
module instr_encoder #(
  parameter int instr_width = 9,
  parameter int num_regs    = 12,
  parameter int imem_depth  = 256,
  parameter int addr_width  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_mnem,
  input  logic [3:0]             in_rd,
  input  logic [3:0]             in_rs,
  input  logic [3:0]             in_rt,
  input  logic [7:0]             in_imm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [addr_width-1:0]  out_addr,
  output logic [instr_width-1:0] out_instr,
  output logic                   err,
  output logic [1:0]             err_code,
  output logic                   halted,
  output logic                   full
);

  typedef enum logic [1:0] {
    st_run  = 2'd0,
    st_halt = 2'd1,
    st_full = 2'd2
  } state_t;

  localparam logic [instr_width-1:0] done_word = 9'b111_000_011;
  localparam logic [addr_width-1:0]  last_addr = addr_width'(imem_depth - 1);

  function automatic logic in_rng(input logic [3:0] x, input logic [3:0] lo, input logic [3:0] hi);
    return (x >= lo) && (x <= hi);
  endfunction

  // Returns {err_code, word}; err_code 0 means the instruction is legal.
  function automatic logic [instr_width+1:0] encode(
    input logic [3:0] mnem,
    input logic [3:0] rd,
    input logic [3:0] rs,
    input logic [3:0] rt,
    input logic [7:0] imm
  );
    logic [1:0]             code;
    logic [instr_width-1:0] word;
    logic [2:0]             rd_m1;
    logic [2:0]             rs_m5;
    code  = 2'd0;
    word  = {instr_width{1'b0}};
    rd_m1 = 3'(rd - 4'd1);
    rs_m5 = 3'(rs - 4'd5);
    case (mnem)
      4'd0, 4'd1, 4'd2: begin
        if (in_rng(rs, 4'd4, 4'd7) && rt <= 4'd3 && rd == 4'd11) word = {3'b000, rs[1:0], rt[1:0], mnem[1:0]};
        else code = 2'd1;
      end
      4'd3: begin
        if (rs <= 4'd3 && in_rng(rt, 4'd8, 4'd11)) word = {3'b000, rs[1:0], rt[1:0], 2'b11};
        else code = 2'd1;
      end
      4'd4: begin
        if (in_rng(rd, 4'd4, 4'd7) && rt <= 4'd3) word = {3'b001, rd[1:0], rt[1:0], 2'b00};
        else code = 2'd1;
      end
      4'd5: begin
        if (in_rng(rs, 4'd4, 4'd7) && rt <= 4'd3) word = {3'b001, rs[1:0], rt[1:0], 2'b01};
        else code = 2'd1;
      end
      4'd6, 4'd7: begin
        if (rd < 4'(num_regs)) word = {3'b001, rd, 1'b1, mnem[0]};
        else code = 2'd1;
      end
      4'd8, 4'd10: begin
        if (in_rng(rs, 4'd4, 4'd7) && rt <= 4'd3 && in_rng(rd, 4'd8, 4'd11))
          word = {(mnem == 4'd8) ? 3'b010 : 3'b100, rs[1:0], rt[1:0], rd[1:0]};
        else code = 2'd1;
      end
      4'd9: begin
        if (!(in_rng(rd, 4'd8, 4'd11) && rs <= 4'd3)) code = 2'd1;
        else if (imm > 8'd3) code = 2'd2;
        else word = {3'b011, rd[1:0], rs[1:0], imm[1:0]};
      end
      4'd11: begin
        if (in_rng(rd, 4'd1, 4'd8) && in_rng(rs, 4'd5, 4'd11)) word = {3'b101, rd_m1, rs_m5};
        else code = 2'd1;
      end
      4'd12: begin
        if (imm[7:6] == {imm[5], imm[5]}) word = {3'b110, imm[5:0]};
        else code = 2'd2;
      end
      4'd13, 4'd14: begin
        if (in_rng(rs, 4'd4, 4'd7) && rt <= 4'd3 && rd == rs) word = {3'b111, rs[1:0], rt[1:0], 1'b0, ~mnem[0]};
        else code = 2'd1;
      end
      4'd15: begin
        if (imm[7:1] != 7'd0) code = 2'd3;
        else if (imm[0]) word = done_word;
        else if (in_rng(rs, 4'd4, 4'd7) && rt <= 4'd3 && rd == rs) word = {3'b111, rs[1:0], rt[1:0], 2'b10};
        else code = 2'd1;
      end
      default: code = 2'd0;
    endcase
    return {code, word};
  endfunction

  state_t                 state_r, state_next_s;
  logic                   in_ready_s;
  logic                   out_valid_r, err_r, halted_r, full_r;
  logic [addr_width-1:0]  out_addr_r;
  logic [instr_width-1:0] out_instr_r, enc_word_s;
  logic [1:0]             err_code_r, enc_code_s;
  logic                   accept_s, wr_s, last_s, done_wr_s;

  assign accept_s  = in_valid && in_ready_s;
  assign wr_s      = out_valid_r && out_ready;
  assign last_s    = (out_addr_r == last_addr);
  assign done_wr_s = wr_s && (out_instr_r == done_word);

  // Combinational encode of the presented instruction fields
  always_comb begin
    {enc_code_s, enc_word_s} = encode(in_mnem, in_rd, in_rs, in_rt, in_imm);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= st_run;
    else        state_r <= state_next_s;
  end

  // Next-state logic: terminal states are left only through clear
  always_comb begin
    state_next_s = state_r;
    if (clear) begin
      state_next_s = st_run;
    end else begin
      case (state_r)
        st_run: begin
          if (done_wr_s)           state_next_s = st_halt;
          else if (wr_s && last_s) state_next_s = st_full;
          else                     state_next_s = st_run;
        end
        st_halt, st_full: state_next_s = state_r;
        default:          state_next_s = st_run;
      endcase
    end
  end

  // Output logic: accept only while running with the output slot free or draining
  always_comb begin
    in_ready_s = (state_r == st_run) && (!out_valid_r || out_ready) && !clear;
  end

  // Output register, address counter and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_addr_r  <= {addr_width{1'b0}};
      out_instr_r <= {instr_width{1'b0}};
      err_r       <= 1'b0;
      err_code_r  <= 2'd0;
      halted_r    <= 1'b0;
      full_r      <= 1'b0;
    end else if (clear) begin
      out_valid_r <= 1'b0;
      out_addr_r  <= {addr_width{1'b0}};
      err_r       <= 1'b0;
      halted_r    <= 1'b0;
      full_r      <= 1'b0;
    end else begin
      err_r <= accept_s && (enc_code_s != 2'd0);
      if (accept_s && enc_code_s != 2'd0) err_code_r <= enc_code_s;
      if (accept_s && enc_code_s == 2'd0) out_instr_r <= enc_word_s;
      // The last address holds rather than wrapping; FULL blocks further writes
      if (wr_s && !last_s) out_addr_r <= out_addr_r + {{(addr_width-1){1'b0}}, 1'b1};
      if (done_wr_s) halted_r <= 1'b1;
      if (wr_s && last_s) full_r <= 1'b1;
      if (state_next_s != st_run)              out_valid_r <= 1'b0;
      else if (accept_s && enc_code_s == 2'd0) out_valid_r <= 1'b1;
      else if (wr_s)                           out_valid_r <= 1'b0;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_addr  = out_addr_r;
  assign out_instr = out_instr_r;
  assign err       = err_r;
  assign err_code  = err_code_r;
  assign halted    = halted_r;
  assign full      = full_r;

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Encodes one assembly-level instruction per handshake into the 9-bit machine word consumed by the core's instruction decoder.
- Streams encoded words with sequential addresses into instruction memory.
- Sits between the bench/loader front end and the instruction-memory write port.
- Validates operand ranges against the fixed register windows of each format; rejects illegal operands without writing.

Parameters:
- instr_width, 9, encoded word width
- num_regs, 12, architectural register count
- imem_depth, 256, instruction memory depth in words
- addr_width, 8, write-address width (clog2 of imem_depth)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous restart: address to 0, leave HALT/FULL, drop pending output
- in_valid  in  1  instruction fields valid
- in_ready  out  1  encoder can accept
- in_mnem  in  4  0 AND,1 SLT,2 OR,3 BEQ,4 LW,5 SW,6 INC,7 NOT,8 ADD,9 ADDI,10 SUB,11 TR,12 JR,13 SRL,14 SRA,15 SLL/DONE per in_imm[0] (0 SLL, 1 DONE)
- in_rd, in_rs, in_rt  in  4 each  register numbers
- in_imm  in  8  immediate (two's complement for JR)
- out_valid  out  1  word pending for memory
- out_ready  in  1  memory accepts word
- out_addr  out  addr_width  write address
- out_instr  out  9  encoded word
- err  out  1  one-cycle pulse on rejected instruction
- err_code  out  2  1 register out of range, 2 immediate out of range, 3 bad SLL/DONE select; holds until next err
- halted  out  1  DONE written
- full  out  1  imem_depth words written

Behaviour:
- Encoding ([8:6] op, low bits per format):
  - AND/SLT/OR: 000, rs-4 (rs 4..7), rt (0..3), sub 00/01/10; rd must be 11.
  - BEQ: 000, rs (0..3), rt-8 (8..11), 11.
  - LW: 001, rd-4 (4..7), rt (0..3), 00.
  - SW: 001, rs-4 (4..7), rt (0..3), 01.
  - INC/NOT: 001, [5:2]=rd (0..11), 10/11.
  - ADD/SUB: 010/100, rs-4 (4..7), rt (0..3), rd-8 (8..11).
  - ADDI: 011, [5:4]=rd-8 (8..11), [3:2]=rs (0..3), [1:0]=imm; imm must be 0..3.
  - TR: 101, [5:3]=rd-1 (1..8), [2:0]=rs-5 (5..11).
  - JR: 110, [5:0]=imm[5:0]; imm[7:6] must equal {imm[5],imm[5]}, range -32..31.
  - SRL/SRA/SLL: 111, rs-4 (4..7), rt (0..3), 00/01/10; rd must equal rs.
  - DONE: 9'b111_000_011.
  - Unchecked fields are don't-care.
  - Mnem 15 with in_imm[7:1] != 0 gives err_code 3.
- Handshake: transfer when in_valid && in_ready. One-entry output register. in_ready = (state==RUN) && (!out_valid || out_ready) && !clear.
- Latency: accepted word appears on out_instr/out_valid next cycle; out_valid holds and out_instr/out_addr stay stable until out_valid && out_ready.
- Legal instruction: loads the output register. Illegal: no load, no address advance; err pulses the cycle after acceptance; err_code updated.
- Address: out_addr starts at 0, increments by 1 on each memory handshake. No wrap. On the handshake at address imem_depth-1, enter FULL.
- FSM:
  - RUN: normal operation.
  - HALT: entered on the memory handshake of a DONE word.
  - FULL: entered on the last-address handshake. DONE at the last address goes to HALT (halted=1, full=1).
  - HALT/FULL: in_ready=0, out_valid=0; leave only via clear or reset.
- Simultaneous events:
  - Memory handshake and new acceptance in one cycle: the new word replaces the old; the address increments once.
  - clear with a pending word: the word is dropped, no write.
  - clear beats in_valid in the same cycle.
- Reset (async, any time): state RUN, out_valid 0, out_addr 0, out_instr 0, err 0, err_code 0, halted 0, full 0. A word pending at reset is lost.

Test Plan:
- ADD rs=5 rt=2 rd=9, out_ready=1 -> out_instr 9'b010_01_10_01, addr 0; next instruction at addr 1.
- JR imm=8'hFD, then JR imm=8'h40 -> 9'b110_111101 written; second rejected, err=1, err_code=2, addr unchanged.
- AND rs=3 -> err_code=1, no write. TR rd=8 rs=11 -> 9'b101_111_110.
- out_ready=0 for 5 cycles after ADDI rd=10 rs=1 imm=3 -> out_instr 9'b011_10_01_11 stable; in_ready=0; single write on release.
- DONE at addr 3 -> halted=1, in_ready=0. clear -> RUN, next word at addr 0.
- imem_depth=4, write 4 legal words -> full=1, in_ready=0. Async reset mid-stall -> all outputs 0 immediately.
